// File: rtl/mux_n_to_one_seq.sv
// Registered N-channel mux with manual select and round-robin auto-scan.
// Output is a valid/ready stage tagged with the source channel index.
`timescale 1ns/1ps
module mux_n_to_one_seq #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 1,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int DWELL_W = 8
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [NUM_CH*DATA_W-1:0] DIN,
  input  logic [NUM_CH-1:0]        EN_MASK,
  input  logic                     MODE,
  input  logic [SEL_W-1:0]         SEL,
  input  logic [DWELL_W-1:0]       DWELL,
  output logic [DATA_W-1:0]        DOUT,
  output logic [SEL_W-1:0]         DOUT_CH,
  output logic                     DOUT_VALID,
  input  logic                     DOUT_READY,
  output logic                     SEL_ERR
);

  localparam int MW = 1 << SEL_W;

  typedef enum logic [1:0] {
    MANUAL,
    SCAN,
    NOCH
  } state_e;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     ptr_q, ptr_d;
  logic [DWELL_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]    dout_q, dout_d;
  logic [SEL_W-1:0]     ch_q, ch_d;
  logic                 vld_q, vld_d;
  logic                 err_q, err_d;

  logic                 load;
  logic                 any_en;
  logic                 sel_ok;
  logic [MW-1:0]        mask_ext;
  logic [DWELL_W-1:0]   dlast;

  // First enabled channel starting at from (incl) or just above it,
  // wrapping at NUM_CH; returns from when nothing qualifies.
  function automatic logic [SEL_W-1:0] find_en(
    input logic [SEL_W-1:0]  from,
    input logic [NUM_CH-1:0] m,
    input logic              incl
  );
    logic [SEL_W-1:0] r;
    logic             hit;
    int               idx;
    r   = from;
    hit = 1'b0;
    for (int i = 0; i <= NUM_CH; i++) begin
      idx = int'(from) + i;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!hit && m[idx] && (incl ? (i < NUM_CH) : (i > 0))) begin
        r   = SEL_W'(idx);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] pick(
    input logic [NUM_CH*DATA_W-1:0] d,
    input logic [SEL_W-1:0]         ch
  );
    logic [DATA_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (SEL_W'(k) == ch) r = d[k*DATA_W +: DATA_W];
    end
    return r;
  endfunction

  // Padding bits are zero, so an out-of-range SEL reads as disabled.
  assign mask_ext = MW'(EN_MASK);
  assign sel_ok   = mask_ext[SEL];
  assign any_en   = |EN_MASK;
  assign load     = !vld_q || DOUT_READY;
  assign dlast    = (DWELL == '0) ? '0 : DWELL - DWELL_W'(1);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ch_d    = ch_q;
    vld_d   = vld_q;
    err_d   = 1'b0;
    if (load) begin
      vld_d = 1'b0;
      unique case (state_q)
        MANUAL: begin
          if (MODE) begin
            cnt_d   = '0;
            state_d = any_en ? SCAN : NOCH;
            if (any_en) begin
              ptr_d = sel_ok ? SEL : find_en('0, EN_MASK, 1'b1);
            end
          end else if (sel_ok) begin
            dout_d = pick(DIN, SEL);
            ch_d   = SEL;
            vld_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        SCAN: begin
          if (!MODE) begin
            state_d = MANUAL;
            cnt_d   = '0;
          end else if (!any_en) begin
            state_d = NOCH;
          end else if (mask_ext[ptr_q]) begin
            dout_d = pick(DIN, ptr_q);
            ch_d   = ptr_q;
            vld_d  = 1'b1;
            // >= so a DWELL shrunk mid-dwell still ends the current stay
            if (cnt_q >= dlast) begin
              cnt_d = '0;
              ptr_d = find_en(ptr_q, EN_MASK, 1'b0);
            end else begin
              cnt_d = cnt_q + DWELL_W'(1);
            end
          end else begin
            ptr_d = find_en(ptr_q, EN_MASK, 1'b0);
            cnt_d = '0;
          end
        end
        NOCH: begin
          if (!MODE) begin
            state_d = MANUAL;
            cnt_d   = '0;
          end else if (any_en) begin
            state_d = SCAN;
            ptr_d   = find_en(ptr_q, EN_MASK, 1'b1);
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = MANUAL;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= MANUAL;
      ptr_q   <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      vld_q   <= vld_d;
      err_q   <= err_d;
    end
  end

  assign DOUT       = dout_q;
  assign DOUT_CH    = ch_q;
  assign DOUT_VALID = vld_q;
  assign SEL_ERR    = err_q;

endmodule

// File: tb/tb_mux_n_to_one_seq.sv
// Scoreboard bench for mux_n_to_one_seq: 4-channel instance under a
// behavioural model, plus a 3-channel instance with directed checks.
`timescale 1ns/1ps
module tb_mux_n_to_one_seq;

  localparam int NC = 4;
  localparam int DW = 8;
  localparam int SW = 2;
  localparam int WW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NC*DW-1:0] din;
  logic [NC-1:0]   mask;
  logic            mode;
  logic [SW-1:0]   sel;
  logic [WW-1:0]   dwell;
  logic            rdy;
  logic [DW-1:0]   dout;
  logic [SW-1:0]   dch;
  logic            dvld;
  logic            serr;

  logic            rst3_n = 1'b0;
  logic [11:0]     din3;
  logic [2:0]      mask3;
  logic            mode3;
  logic [1:0]      sel3;
  logic [7:0]      dwell3;
  logic            rdy3;
  logic [3:0]      dout3;
  logic [1:0]      dch3;
  logic            dvld3;
  logic            serr3;

  mux_n_to_one_seq #(
    .NUM_CH(NC), .DATA_W(DW), .DWELL_W(WW)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .DIN(din), .EN_MASK(mask),
    .MODE(mode), .SEL(sel), .DWELL(dwell), .DOUT(dout),
    .DOUT_CH(dch), .DOUT_VALID(dvld), .DOUT_READY(rdy),
    .SEL_ERR(serr)
  );

  mux_n_to_one_seq #(
    .NUM_CH(3), .DATA_W(4), .DWELL_W(8)
  ) u_dut3 (
    .CLK(clk), .RST_N(rst3_n), .DIN(din3), .EN_MASK(mask3),
    .MODE(mode3), .SEL(sel3), .DWELL(dwell3), .DOUT(dout3),
    .DOUT_CH(dch3), .DOUT_VALID(dvld3), .DOUT_READY(rdy3),
    .SEL_ERR(serr3)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    int d;
    int ch;
  } item_t;

  item_t exp_q[$];
  bit    err_q[$];
  int    acc_log[$];

  typedef enum {S_MAN, S_SCAN, S_NONE} ms_e;
  ms_e m_st  = S_MAN;
  int  m_ptr = 0;
  int  m_cnt = 0;
  bit  m_vld = 1'b0;

  function automatic int next_en(int from, logic [NC-1:0] m, bit incl);
    for (int i = (incl ? 0 : 1); i < NC + (incl ? 0 : 1); i++) begin
      if (m[(from + i) % NC]) return (from + i) % NC;
    end
    return from;
  endfunction

  function automatic int slice(logic [NC*DW-1:0] d, int ch);
    return int'((d >> (ch * DW)) & 32'hff);
  endfunction

  task automatic emit(int ch);
    item_t it;
    it.d  = slice(din, ch);
    it.ch = ch;
    exp_q.push_back(it);
    m_vld = 1'b1;
  endtask

  // Predicts what the DUT does at the clock edge now occurring.
  task automatic model_step();
    bit e;
    int stay;
    e = 1'b0;
    stay = (dwell == 0) ? 1 : int'(dwell);
    if (!m_vld || rdy) begin
      m_vld = 1'b0;
      case (m_st)
        S_MAN: begin
          if (mode) begin
            m_cnt = 0;
            if (mask == 0) m_st = S_NONE;
            else begin
              m_st  = S_SCAN;
              m_ptr = mask[sel] ? int'(sel) : next_en(0, mask, 1'b1);
            end
          end else if (mask[sel]) emit(int'(sel));
          else e = 1'b1;
        end
        S_SCAN: begin
          if (!mode) begin
            m_st  = S_MAN;
            m_cnt = 0;
          end else if (mask == 0) m_st = S_NONE;
          else if (mask[m_ptr]) begin
            emit(m_ptr);
            m_cnt++;
            if (m_cnt >= stay) begin
              m_cnt = 0;
              m_ptr = next_en(m_ptr, mask, 1'b0);
            end
          end else begin
            m_ptr = next_en(m_ptr, mask, 1'b0);
            m_cnt = 0;
          end
        end
        default: begin
          if (!mode) begin
            m_st  = S_MAN;
            m_cnt = 0;
          end else if (mask != 0) begin
            m_st  = S_SCAN;
            m_ptr = next_en(m_ptr, mask, 1'b1);
            m_cnt = 0;
          end
        end
      endcase
    end
    err_q.push_back(e);
  endtask

  task automatic model_reset();
    m_st  = S_MAN;
    m_ptr = 0;
    m_cnt = 0;
    m_vld = 1'b0;
    exp_q.delete();
    err_q.delete();
    acc_log.delete();
  endtask

  task automatic cyc(input bit md, input int s, input logic [3:0] mk,
                     input int dw, input bit r, input logic [31:0] d);
    mode  = md;
    sel   = SW'(s);
    mask  = mk;
    dwell = WW'(dw);
    rdy   = r;
    din   = d;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_seq(input string nm, input int exp[$]);
    chk({nm, "_len"}, int'(acc_log.size() >= exp.size()), 1);
    for (int i = 0; i < exp.size(); i++) begin
      if (i < acc_log.size()) chk(nm, acc_log[i], exp[i]);
    end
  endtask

  item_t mon_it;
  bit    mon_e;

  always @(negedge clk) begin
    if (rst_n) begin
      if (dvld && rdy) begin
        acc_log.push_back(int'(dch));
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          mon_it = exp_q.pop_front();
          chk("out_data", int'(dout), mon_it.d);
          chk("out_ch", int'(dch), mon_it.ch);
        end
      end
      if (err_q.size() > 0) begin
        mon_e = err_q.pop_front();
        if (mon_e || serr) chk("sel_err", int'(serr), int'(mon_e));
      end else if (serr) chk("sel_err_spurious", 1, 0);
    end
  end

  task automatic step3();
    @(posedge clk);
    #1;
  endtask

  task automatic run_u3();
    mode3  = 1'b0;
    mask3  = 3'b111;
    rdy3   = 1'b1;
    din3   = 12'hCBA;
    dwell3 = 8'd1;
    sel3   = 2'd2;
    rst3_n = 1'b1;
    step3();
    chk("u3_dout", int'(dout3), 'hC);
    chk("u3_ch", int'(dch3), 2);
    chk("u3_vld", int'(dvld3), 1);
    sel3 = 2'd3;
    step3();
    chk("u3_err", int'(serr3), 1);
    chk("u3_err_vld", int'(dvld3), 0);
    chk("u3_err_hold", int'(dout3), 'hC);
    sel3 = 2'd1;
    step3();
    chk("u3_dout_b", int'(dout3), 'hB);
    chk("u3_err_clr", int'(serr3), 0);
    mode3 = 1'b1;
    mask3 = 3'b101;
    step3();
    chk("u3_enter_vld", int'(dvld3), 0);
    for (int i = 0; i < 4; i++) begin
      step3();
      chk("u3_scan_ch", int'(dch3), (i % 2) * 2);
      chk("u3_scan_d", int'(dout3), (i % 2) ? 'hC : 'hA);
      chk("u3_scan_err", int'(serr3), 0);
    end
    rst3_n = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [31:0] D0 = 32'h44332211;

  initial begin
    int q_a[$];
    int q_b[$];
    int q_c[$];
    int q_d[$];
    int q_e[$];
    int c;
    bit rmode;
    logic [3:0] rmask;
    int rdw;

    mode  = 1'b0;
    sel   = 2'd2;
    mask  = 4'hF;
    dwell = 8'd1;
    rdy   = 1'b1;
    din   = D0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", int'(dout), 0);
    chk("rst_ch", int'(dch), 0);
    chk("rst_vld", int'(dvld), 0);
    chk("rst_err", int'(serr), 0);

    run_u3();
    chk("rst_hold_vld", int'(dvld), 0);
    chk("rst_hold_dout", int'(dout), 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    cyc(0, 2, 4'hF, 1, 1, D0);
    chk("basic_dout", int'(dout), 'h33);
    chk("basic_ch", int'(dch), 2);
    chk("basic_vld", int'(dvld), 1);

    cyc(0, 1, 4'b1101, 1, 1, D0);
    chk("merr_pulse", int'(serr), 1);
    chk("merr_vld", int'(dvld), 0);
    cyc(0, 0, 4'b1101, 1, 1, D0);
    chk("merr_clear", int'(serr), 0);
    chk("merr_recover", int'(dout), 'h11);

    cyc(1, 0, 4'b1011, 2, 1, D0);
    acc_log.delete();
    repeat (9) cyc(1, 0, 4'b1011, 2, 1, D0);
    q_a = '{0, 0, 1, 1, 3, 3, 0, 0};
    check_seq("dwell2_seq", q_a);

    cyc(0, 0, 4'b1011, 0, 1, D0);
    cyc(1, 0, 4'b1011, 0, 1, D0);
    acc_log.delete();
    repeat (5) cyc(1, 0, 4'b1011, 0, 1, D0);
    q_b = '{0, 1, 3, 0};
    check_seq("dwell0_seq", q_b);

    repeat (3) cyc(1, 0, 4'hF, 1, 1, D0);
    c = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1, 0, 4'hF, 1, 0, $urandom);
      chk("stall_vld", int'(dvld), 1);
      chk("stall_q", exp_q.size(), 1);
      if (exp_q.size() > 0) begin
        c = exp_q[0].ch;
        chk("stall_ch", int'(dch), exp_q[0].ch);
        chk("stall_dout", int'(dout), exp_q[0].d);
      end
    end
    acc_log.delete();
    repeat (4) cyc(1, 0, 4'hF, 1, 1, D0);
    for (int i = 0; i < 4; i++) q_c.push_back((c + i) % NC);
    check_seq("bp_resume", q_c);

    cyc(1, 0, 4'h0, 1, 1, D0);
    cyc(1, 0, 4'h0, 1, 1, D0);
    chk("nochan_vld", int'(dvld), 0);
    cyc(1, 0, 4'h0, 1, 1, D0);
    cyc(1, 0, 4'b0100, 1, 1, D0);
    acc_log.delete();
    repeat (5) cyc(1, 0, 4'b0100, 1, 1, D0);
    q_d = '{2, 2, 2, 2};
    check_seq("single_ch", q_d);

    cyc(1, 0, 4'hF, 1, 0, D0);
    chk("pre_rst_vld", int'(dvld), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(dvld), 0);
    chk("arst_dout", int'(dout), 0);
    chk("arst_ch", int'(dch), 0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 4'hF, 1, 1, D0);
    acc_log.delete();
    repeat (3) cyc(1, 0, 4'hF, 1, 1, D0);
    q_e = '{0, 1};
    check_seq("arst_restart", q_e);

    rmode = 1'b1;
    rmask = 4'hF;
    rdw   = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rmode = ~rmode;
      if ($urandom_range(0, 9) == 0) rmask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) rdw = $urandom_range(0, 3);
      cyc(rmode, $urandom_range(0, 3), rmask, rdw,
          $urandom_range(0, 3) != 0, $urandom);
    end

    repeat (6) cyc(1, 0, 4'h0, 1, 1, D0);
    @(negedge clk);
    #1;
    chk("drain_out_q", exp_q.size(), 0);
    chk("drain_err_q", err_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_n_to_one_seq.md
Name: mux_n_to_one_seq

Overview:
Parametrised, registered N-channel, W-bit multiplexer. It replaces the combinational 4-to-1 mux wherever a selected channel must be sampled into a clocked pipeline.
- Manual-select mode and an auto-scan mode. Auto-scan steps round-robin through the enabled channels with a programmable dwell time.
- Output carries a valid/ready handshake and the channel tag.
- Sits between sensor/data sources and downstream consumers that apply backpressure.

Parameters:
NUM_CH, 4, number of input channels (>=2, need not be a power of 2)
DATA_W, 1, bits per channel
SEL_W, $clog2(NUM_CH), width of select/channel tag (derived, do not override)
DWELL_W, 8, width of dwell-count input

Ports:
CLK  in  1  clock, all state updates on rising edge
RST_N  in  1  asynchronous active-low reset
DIN  in  NUM_CH*DATA_W  channel data, channel k at bits [k*DATA_W +: DATA_W]
EN_MASK  in  NUM_CH  per-channel enable, 1 = channel eligible
MODE  in  1  0 = manual (SEL), 1 = auto-scan
SEL  in  SEL_W  channel select in manual mode
DWELL  in  DWELL_W  accepted samples per channel before scan advances; 0 treated as 1
DOUT  out  DATA_W  registered selected data
DOUT_CH  out  SEL_W  channel index of DOUT
DOUT_VALID  out  1  DOUT/DOUT_CH valid
DOUT_READY  in  1  consumer accepts when DOUT_VALID && DOUT_READY
SEL_ERR  out  1  one-cycle pulse: manual SEL >= NUM_CH or SEL channel disabled

Behaviour:
- Reset (RST_N=0, async): DOUT=0, DOUT_CH=0, DOUT_VALID=0, SEL_ERR=0, scan pointer PTR=0, dwell counter CNT=0, state=MANUAL. Takes effect immediately, including mid-transfer; no partial output survives.
- Load slot: LOAD = !DOUT_VALID || DOUT_READY. Latency DIN→DOUT is 1 cycle.
- While DOUT_VALID && !DOUT_READY: DOUT, DOUT_CH, DOUT_VALID, PTR and CNT all hold.
- States: MANUAL, SCAN, NOCH (scan with EN_MASK==0).
- MANUAL, on LOAD:
  - SEL < NUM_CH and EN_MASK[SEL]=1: DOUT=DIN slice SEL, DOUT_CH=SEL, DOUT_VALID=1.
  - Otherwise: DOUT_VALID=0, SEL_ERR=1 for that cycle, DOUT/DOUT_CH hold.
- MANUAL→SCAN when MODE=1:
  - PTR = SEL if SEL valid and enabled, else lowest enabled channel.
  - CNT=0.
  - Goes to NOCH instead if EN_MASK==0.
- SCAN, on LOAD:
  - EN_MASK[PTR]=1: emit PTR's data (DOUT_VALID=1, DOUT_CH=PTR). If CNT == max(DWELL,1)-1: CNT=0 and PTR = next enabled channel above PTR, wrapping NUM_CH-1→0. Else CNT+1.
  - EN_MASK[PTR]=0 (mask changed): no emit (DOUT_VALID=0), PTR advances to next enabled channel, CNT=0.
  - Only one enabled channel: PTR stays on it; CNT still wraps.
- SCAN→NOCH when EN_MASK==0: DOUT_VALID clears at next LOAD, PTR holds. NOCH→SCAN when any mask bit sets; resumes from next enabled channel at or above PTR.
- SCAN/NOCH→MANUAL when MODE=0: effective on the next LOAD, CNT=0. A held output is not dropped.
- DWELL is sampled every cycle. A change mid-dwell applies to the current compare.
- SEL_ERR never asserts in SCAN/NOCH.
- Mode, mask and SEL changes during a stall apply only at the next LOAD.

Test Plan:
- Reset/basic: NUM_CH=4, DATA_W=8, MODE=0, READY=1, DIN={8'h44,8'h33,8'h22,8'h11}, SEL=2 → after release, 1 cycle later DOUT=8'h33, DOUT_CH=2, VALID=1. During reset all outputs are 0.
- Manual error: SEL=1 with EN_MASK=4'b1101 → SEL_ERR pulses 1 cycle, VALID=0. Same check with NUM_CH=3, SEL=3.
- Scan + dwell: MODE=1, EN_MASK=4'b1011, DWELL=2, READY=1 → DOUT_CH sequence 0,0,1,1,3,3,0,0. With DWELL=0 → 0,1,3,0.
- Backpressure: scan, DWELL=1, READY=0 for 5 cycles mid-stream → DOUT/DOUT_CH frozen, no channel skipped. After READY=1 the sequence continues exactly.
- Mask edge: clear EN_MASK to 0 during scan → VALID drops after the pending handshake. Set EN_MASK=4'b0100 → DOUT_CH=2 continuously.
- Async reset mid-stall: assert RST_N=0 between clock edges while VALID=1 && READY=0 → VALID=0 immediately. After release, scan restarts from channel 0.
